dram_lsu: RTL

//  Load/store initiator that drives the data-memory port (dm_rd_ctrl/dm_wr_ctrl/dm_addr/dm_din/dm_dout) from the MEM stage.

---
 rtl/dram_lsu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dram_lsu.sv
// Load/store unit driving the data-memory port: splits word-crossing loads, serialises stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses respond with an error instead of being split.
module dram_lsu #(
    parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
    parameter logic [63:0] MEM_BYTES = 64'd16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  dm_rd_ctrl,
    output logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_din,
    input  logic [63:0] dm_dout
);

    typedef enum logic [2:0] {IDLE, LD0, LD1, ST, RESP} state_t;

    state_t      state_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [63:0] lo_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [2:0]  beat_reg;

    logic [3:0]  req_n;
    logic [64:0] req_end;
    logic [64:0] win_end;
    logic        req_bad;
    logic        trap;
    logic [3:0]  n_reg;
    logic [2:0]  off;
    logic        crossing;
    logic        wide_store;
    logic        last_beat;
    logic [5:0]  hi_shift;

    assign req_n    = 4'd1 << req_size;
    assign req_end  = {1'b0, req_addr} + 65'(req_n);
    assign win_end  = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap     = (req_addr[2:0] & (req_n[2:0] - 3'd1)) != 3'd0;
`else
    assign trap     = 1'b0;
`endif
    assign req_bad  = (req_addr < MEM_BASE) || (req_end > win_end) || trap;

    assign n_reg      = 4'd1 << size_reg;
    assign off        = addr_reg[2:0];
    assign crossing   = (5'(off) + 5'(n_reg)) > 5'd8;
    assign wide_store = (off == 3'd0) && size_reg[1];
    assign last_beat  = wide_store || (beat_reg == 3'(n_reg - 4'd1));
    // 8*(8-off); only used when crossing, where off is never 0
    assign hi_shift   = {3'd0 - off, 3'b000};
    assign req_ready  = (state_reg == IDLE);

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'd0:    extend = uns ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
            2'd1:    extend = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    extend = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            lo_reg       <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            beat_reg     <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (req_valid) begin
                    addr_reg     <= req_addr;
                    wdata_reg    <= req_wdata;
                    size_reg     <= req_size;
                    unsigned_reg <= req_unsigned;
                    beat_reg     <= '0;
                    if (req_bad) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        state_reg <= req_we ? ST : LD0;
                    end
                end
                LD0: begin
                    lo_reg <= dm_dout;
                    if (crossing) begin
                        state_reg <= LD1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extend(dm_dout, size_reg, unsigned_reg);
                        rsp_err   <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                LD1: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= extend(lo_reg | (dm_dout << hi_shift), size_reg, unsigned_reg);
                    rsp_err   <= 1'b0;
                    state_reg <= RESP;
                end
                ST: begin
                    if (last_beat) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state_reg <= RESP;
                    end else begin
                        beat_reg <= beat_reg + 3'd1;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory port is a pure decode of state so async reset silences it immediately
    always_comb begin
        dm_rd_ctrl = 3'b000;
        dm_wr_ctrl = 3'b000;
        dm_addr    = '0;
        dm_din     = '0;
        case (state_reg)
            LD0: begin
                dm_rd_ctrl = 3'b101;
                dm_addr    = addr_reg;
            end
            LD1: begin
                dm_rd_ctrl = 3'b101;
                dm_addr    = {addr_reg[63:3], 3'b000} + 64'd8;
            end
            ST: begin
                if (wide_store) begin
                    dm_addr = addr_reg;
                    if (size_reg[0]) begin
                        dm_wr_ctrl = 3'b100;
                        dm_din     = wdata_reg;
                    end else begin
                        dm_wr_ctrl = 3'b011;
                        dm_din     = {32'd0, wdata_reg[31:0]};
                    end
                end else begin
                    dm_wr_ctrl = 3'b001;
                    dm_addr    = addr_reg + 64'(beat_reg);
                    dm_din     = {8{wdata_reg[{beat_reg, 3'b000} +: 8]}};
                end
            end
            default: ;
        endcase
    end

endmodule
